// File: rtl/pulse_measure_pkg.sv
// Shared types and constants for the six-channel pulse measurement block.
package pulse_measure_pkg;

    localparam int unsigned NUM_CH    = 6;
    localparam int unsigned DEF_CNT_W = 16;

    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOW   = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_e;

endpackage

// File: rtl/pulse_meas_ch.sv
// One measurement channel: delay from aligned trigger to falling edge, then low width.
module pulse_meas_ch
    import pulse_measure_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             trig,
    input  logic             pulse,
    output logic [CNT_W-1:0] meas_delay,
    output logic [CNT_W-1:0] meas_width,
    output logic             valid,
    output logic             timeout,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    ch_state_e        state;
    ch_state_e        state_nxt;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] dcnt_nxt;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] wcnt_nxt;
    logic [CNT_W-1:0] delay_nxt;
    logic [CNT_W-1:0] width_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic             overflow_nxt;
    logic             pulse_q;

    logic [CNT_W-1:0] dinc_c;
    logic [CNT_W-1:0] winc_c;
    logic             fall_c;
    logic             dsat_c;
    logic             wsat_c;

    assign dinc_c = dcnt + CNT_W'(1);
    assign winc_c = wcnt + CNT_W'(1);
    assign fall_c = pulse_q & ~pulse;
    assign dsat_c = (dinc_c == CNT_SAT);
    assign wsat_c = (winc_c == CNT_SAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Disable beats trigger, trigger beats any in-flight measurement or edge.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else if (trig) begin
            state_nxt = ST_ARMED;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (fall_c) begin
                        state_nxt = ST_LOW;
                    end else if (dsat_c) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_LOW: begin
                    if (pulse || wsat_c) begin
                        state_nxt = ST_DONE;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // Counter and result updates; meas_* deliberately hold across disable.
    always_comb begin
        dcnt_nxt     = dcnt;
        wcnt_nxt     = wcnt;
        delay_nxt    = meas_delay;
        width_nxt    = meas_width;
        valid_nxt    = valid;
        timeout_nxt  = timeout;
        overflow_nxt = overflow;
        if (!enable) begin
            valid_nxt    = 1'b0;
            timeout_nxt  = 1'b0;
            overflow_nxt = 1'b0;
        end else if (trig) begin
            dcnt_nxt     = '0;
            wcnt_nxt     = '0;
            valid_nxt    = 1'b0;
            timeout_nxt  = 1'b0;
            overflow_nxt = 1'b0;
        end else begin
            case (state)
                ST_ARMED: begin
                    dcnt_nxt = dinc_c;
                    if (fall_c) begin
                        delay_nxt = dinc_c;
                        wcnt_nxt  = CNT_W'(1);
                    end else if (dsat_c) begin
                        delay_nxt   = CNT_SAT;
                        width_nxt   = '0;
                        timeout_nxt = 1'b1;
                        valid_nxt   = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (pulse) begin
                        width_nxt = wcnt;
                        valid_nxt = 1'b1;
                    end else begin
                        wcnt_nxt = winc_c;
                        if (wsat_c) begin
                            width_nxt    = CNT_SAT;
                            overflow_nxt = 1'b1;
                            valid_nxt    = 1'b1;
                        end
                    end
                end
                default: begin
                    dcnt_nxt = dcnt;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pulse_q    <= 1'b1;
            dcnt       <= '0;
            wcnt       <= '0;
            meas_delay <= '0;
            meas_width <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            pulse_q    <= pulse;
            dcnt       <= dcnt_nxt;
            wcnt       <= wcnt_nxt;
            meas_delay <= delay_nxt;
            meas_width <= width_nxt;
            valid      <= valid_nxt;
            timeout    <= timeout_nxt;
            overflow   <= overflow_nxt;
        end
    end

endmodule

// File: rtl/pulse_measure.sv
// Six-channel pulse delay/width measurement with shared input synchronizer.
module pulse_measure
    import pulse_measure_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] enable,
    input  logic              trigger,
    input  logic [NUM_CH-1:0] pulse_in,
    output logic [CNT_W-1:0]  meas_delay_0,
    output logic [CNT_W-1:0]  meas_delay_1,
    output logic [CNT_W-1:0]  meas_delay_2,
    output logic [CNT_W-1:0]  meas_delay_3,
    output logic [CNT_W-1:0]  meas_delay_4,
    output logic [CNT_W-1:0]  meas_delay_5,
    output logic [CNT_W-1:0]  meas_width_0,
    output logic [CNT_W-1:0]  meas_width_1,
    output logic [CNT_W-1:0]  meas_width_2,
    output logic [CNT_W-1:0]  meas_width_3,
    output logic [CNT_W-1:0]  meas_width_4,
    output logic [CNT_W-1:0]  meas_width_5,
    output logic [NUM_CH-1:0] valid,
    output logic [NUM_CH-1:0] timeout,
    output logic [NUM_CH-1:0] overflow
);

    logic [NUM_CH-1:0] pulse_s;
    logic              trig_s;
    logic [CNT_W-1:0]  delay_a [NUM_CH];
    logic [CNT_W-1:0]  width_a [NUM_CH];

    // Trigger rides a pipeline of equal depth so trigger-to-edge spacing is preserved.
    if (SYNC_STAGES == 0) begin : g_nosync
        assign pulse_s = pulse_in;
        assign trig_s  = trigger;
    end else begin : g_sync
        logic [NUM_CH-1:0] pulse_pipe [SYNC_STAGES];
        logic              trig_pipe  [SYNC_STAGES];

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    pulse_pipe[i] <= '1;
                    trig_pipe[i]  <= 1'b0;
                end
            end else begin
                pulse_pipe[0] <= pulse_in;
                trig_pipe[0]  <= trigger;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    pulse_pipe[i] <= pulse_pipe[i-1];
                    trig_pipe[i]  <= trig_pipe[i-1];
                end
            end
        end

        assign pulse_s = pulse_pipe[SYNC_STAGES-1];
        assign trig_s  = trig_pipe[SYNC_STAGES-1];
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pulse_meas_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable[k]),
            .trig       (trig_s),
            .pulse      (pulse_s[k]),
            .meas_delay (delay_a[k]),
            .meas_width (width_a[k]),
            .valid      (valid[k]),
            .timeout    (timeout[k]),
            .overflow   (overflow[k])
        );
    end

    assign meas_delay_0 = delay_a[0];
    assign meas_delay_1 = delay_a[1];
    assign meas_delay_2 = delay_a[2];
    assign meas_delay_3 = delay_a[3];
    assign meas_delay_4 = delay_a[4];
    assign meas_delay_5 = delay_a[5];
    assign meas_width_0 = width_a[0];
    assign meas_width_1 = width_a[1];
    assign meas_width_2 = width_a[2];
    assign meas_width_3 = width_a[3];
    assign meas_width_4 = width_a[4];
    assign meas_width_5 = width_a[5];

endmodule
